slot_pool: RTL and testbench

//   Allocator for a pool of W slots, each either free or busy. Offers one free

---
 rtl/slot_pool.sv | 140 ++++++++++++++
 tb/tb_slot_pool.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/slot_pool.sv
// Free/busy slot allocator: offers one free slot per cycle, found by a circular
// search below a rotating pointer, and accepts releases from a producer.
module slot_pool #(
    parameter  int W  = 32,
    localparam int IW = $clog2(W),
    localparam int CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          arst_n,
    output logic          alloc_vld_o,
    output logic [IW-1:0] alloc_idx_o,
    input  logic          alloc_ack_i,
    input  logic          rel_vld_i,
    input  logic [IW-1:0] rel_idx_i,
    input  logic          clr_i,
    output logic [W-1:0]  busy_o,
    output logic [CW-1:0] cnt_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          rel_err_o
);

    localparam int          WP  = 1 << IW;
    localparam logic [IW:0] W_L = (IW + 1)'(W);

    if (W < 2) begin : g_bad_w
        $error("slot_pool: W must be >= 2");
    end

    // Circular search for a free slot: p-1, p-2, .., 0, W-1, .., p.
    function automatic logic [IW:0] search_free(input logic [W-1:0] busy, input logic [IW-1:0] p);
        logic [IW:0] res;
        logic        found;
        int          j;
        res   = '0;
        found = 1'b0;
        for (int k = 1; k <= W; k++) begin
            j = (int'(p) >= k) ? (int'(p) - k) : (int'(p) - k + W);
            if (!found && !busy[j]) begin
                found = 1'b1;
                res   = {1'b1, IW'(j)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // One-hot decode of a slot index; indices >= W decode to zero.
    function automatic logic [W-1:0] onehot(input logic [IW-1:0] idx);
        logic [W-1:0] res;
        for (int i = 0; i < W; i++) begin
            res[i] = (idx == IW'(i));
        end
        return res;
    endfunction

    logic [W-1:0]  busy_q, busy_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] cand_q;
    logic          cand_vld_q;
    logic          err_q, err_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;

    logic [WP-1:0] busy_pad_s;
    logic          ack_ok_s;
    logic          rel_ok_s;
    logic [IW:0]   search_s;

    // Next-state: release clears its bit, ack sets the offered bit; clear wins.
    always_comb begin
        busy_d     = busy_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;
        busy_pad_s = WP'(busy_q);
        ack_ok_s   = alloc_ack_i && cand_vld_q;
        rel_ok_s   = rel_vld_i && ({1'b0, rel_idx_i} < W_L) && busy_pad_s[rel_idx_i];
        if (clr_i) begin
            busy_d = '0;
            ptr_d  = '0;
            cnt_d  = '0;
        end else begin
            if (rel_vld_i && !rel_ok_s) begin
                err_d = 1'b1;
            end else begin
                err_d = 1'b0;
            end
            if (rel_ok_s) begin
                busy_d = busy_d & ~onehot(rel_idx_i);
            end else begin
                busy_d = busy_d;
            end
            if (ack_ok_s) begin
                busy_d = busy_d | onehot(cand_q);
                ptr_d  = cand_q;
            end else begin
                ptr_d = ptr_q;
            end
            cnt_d = cnt_q + CW'(ack_ok_s) - CW'(rel_ok_s);
        end
        search_s = search_free(busy_d, ptr_d);
        full_d   = (cnt_d == CW'(W));
        empty_d  = (cnt_d == '0);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            busy_q     <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            cand_q     <= IW'(W - 1);
            cand_vld_q <= 1'b1;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
        end else begin
            busy_q     <= busy_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            cand_q     <= search_s[IW-1:0];
            cand_vld_q <= search_s[IW];
            full_q     <= full_d;
            empty_q    <= empty_d;
        end
    end

    assign alloc_vld_o = cand_vld_q;
    assign alloc_idx_o = cand_q;
    assign busy_o      = busy_q;
    assign cnt_o       = cnt_q;
    assign full_o      = full_q;
    assign empty_o     = empty_q;
    assign rel_err_o   = err_q;

endmodule

// File: tb/tb_slot_pool.sv
// Directed bench for slot_pool: a W=8 instance and a W=6 instance.
module tb_slot_pool;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;

    logic       vld8, ack8, rv8, clr8, full8, empty8, err8;
    logic [2:0] idx8, ri8;
    logic [7:0] busy8;
    logic [3:0] cnt8;

    logic       vld6, ack6, rv6, clr6, full6, empty6, err6;
    logic [2:0] idx6, ri6;
    logic [5:0] busy6;
    logic [2:0] cnt6;

    slot_pool #(.W(8)) u_dut8 (
        .clk(clk), .arst_n(rst_n),
        .alloc_vld_o(vld8), .alloc_idx_o(idx8), .alloc_ack_i(ack8),
        .rel_vld_i(rv8), .rel_idx_i(ri8), .clr_i(clr8),
        .busy_o(busy8), .cnt_o(cnt8), .full_o(full8), .empty_o(empty8),
        .rel_err_o(err8)
    );

    slot_pool #(.W(6)) u_dut6 (
        .clk(clk), .arst_n(rst_n),
        .alloc_vld_o(vld6), .alloc_idx_o(idx6), .alloc_ack_i(ack6),
        .rel_vld_i(rv6), .rel_idx_i(ri6), .clr_i(clr6),
        .busy_o(busy6), .cnt_o(cnt6), .full_o(full6), .empty_o(empty6),
        .rel_err_o(err6)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int exp6 [6] = '{5, 4, 3, 2, 1, 0};
    int exp8 [4] = '{2, 1, 0, 6};

    initial begin
        rst_n = 1'b0;
        {ack8, rv8, clr8, ri8} = '0;
        {ack6, rv6, clr6, ri6} = '0;
        step();
        step();
        rst_n = 1'b1;

        chk("rst8_vld", 32'(vld8), 32'd1);
        chk("rst8_idx", 32'(idx8), 32'd7);
        chk("rst8_empty", 32'(empty8), 32'd1);
        chk("rst8_full", 32'(full8), 32'd0);
        chk("rst8_cnt", 32'(cnt8), 32'd0);
        chk("rst6_idx", 32'(idx6), 32'd5);

        // W=6: out-of-range release, then fill
        rv6 = 1'b1; ri6 = 3'd7;
        step();
        rv6 = 1'b0;
        chk("w6_err_oor", 32'(err6), 32'd1);
        chk("w6_busy_oor", 32'(busy6), 32'h00);
        step();
        chk("w6_err_clear", 32'(err6), 32'd0);
        for (int i = 0; i < 6; i++) begin
            chk("w6_fill_vld", 32'(vld6), 32'd1);
            chk("w6_fill_idx", 32'(idx6), 32'(exp6[i]));
            ack6 = 1'b1;
            step();
            ack6 = 1'b0;
        end
        chk("w6_full", 32'(full6), 32'd1);
        chk("w6_full_vld", 32'(vld6), 32'd0);
        chk("w6_cnt", 32'(cnt6), 32'd6);
        chk("w6_busy", 32'(busy6), 32'h3F);
        rv6 = 1'b1; ri6 = 3'd6;
        step();
        rv6 = 1'b0;
        chk("w6_err_6", 32'(err6), 32'd1);
        chk("w6_cnt_6", 32'(cnt6), 32'd6);

        // W=8 test 1: four back-to-back acks
        for (int i = 0; i < 4; i++) begin
            chk("t1_idx", 32'(idx8), 32'(7 - i));
            ack8 = 1'b1;
            step();
            ack8 = 1'b0;
            chk("t1_cnt", 32'(cnt8), 32'(i + 1));
        end
        chk("t1_busy", 32'(busy8), 32'hF0);
        step();
        chk("t1_hold_idx", 32'(idx8), 32'd3);

        // Test 3: same-cycle ack of 3 and release of 6
        ack8 = 1'b1; rv8 = 1'b1; ri8 = 3'd6;
        step();
        ack8 = 1'b0; rv8 = 1'b0;
        chk("t3_busy", 32'(busy8), 32'hB8);
        chk("t3_cnt", 32'(cnt8), 32'd4);
        chk("t3_idx", 32'(idx8), 32'd2);
        chk("t3_err", 32'(err8), 32'd0);

        // Test 4: release of a free slot
        rv8 = 1'b1; ri8 = 3'd1;
        step();
        rv8 = 1'b0;
        chk("t4_err", 32'(err8), 32'd1);
        chk("t4_busy", 32'(busy8), 32'hB8);
        chk("t4_cnt", 32'(cnt8), 32'd4);
        step();
        chk("t4_err_pulse", 32'(err8), 32'd0);

        // Test 2: fill, ack while full, release while full
        for (int i = 0; i < 4; i++) begin
            chk("t2_fill_idx", 32'(idx8), 32'(exp8[i]));
            ack8 = 1'b1;
            step();
            ack8 = 1'b0;
        end
        chk("t2_full", 32'(full8), 32'd1);
        chk("t2_vld", 32'(vld8), 32'd0);
        chk("t2_cnt", 32'(cnt8), 32'd8);
        ack8 = 1'b1;
        step();
        ack8 = 1'b0;
        chk("t2_ign_cnt", 32'(cnt8), 32'd8);
        chk("t2_ign_err", 32'(err8), 32'd0);
        rv8 = 1'b1; ri8 = 3'd3;
        step();
        rv8 = 1'b0;
        chk("t2_rel_vld", 32'(vld8), 32'd1);
        chk("t2_rel_idx", 32'(idx8), 32'd3);
        chk("t2_rel_cnt", 32'(cnt8), 32'd7);
        chk("t2_rel_full", 32'(full8), 32'd0);

        // Test 6: clear beats ack and release
        ack8 = 1'b1;
        step();
        ack8 = 1'b0;
        chk("t6_busy_ff", 32'(busy8), 32'hFF);
        clr8 = 1'b1; ack8 = 1'b1; rv8 = 1'b1; ri8 = 3'd2;
        step();
        clr8 = 1'b0; ack8 = 1'b0; rv8 = 1'b0;
        chk("t6_clr_busy", 32'(busy8), 32'h00);
        chk("t6_clr_empty", 32'(empty8), 32'd1);
        chk("t6_clr_cnt", 32'(cnt8), 32'd0);
        chk("t6_clr_idx", 32'(idx8), 32'd7);
        chk("t6_clr_err", 32'(err8), 32'd0);

        // Async reset in the middle of an ack burst
        ack8 = 1'b1;
        step();
        step();
        chk("t6_burst_cnt", 32'(cnt8), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_arst_busy", 32'(busy8), 32'h00);
        chk("t6_arst_idx", 32'(idx8), 32'd7);
        chk("t6_arst_empty", 32'(empty8), 32'd1);
        ack8 = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("t6_post_idx", 32'(idx8), 32'd7);
        chk("t6_post_err", 32'(err8), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
